// File: rtl/lsu_mem_if.sv
// lsu_mem_if: load/store unit driving a req/ack data-memory bus, stalling the core until each access completes
module lsu_mem_if #(
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  req_valid_i,
  input  logic [1:0]            store_type_i,
  input  logic                  load_en_i,
  input  logic [2:0]            load_type_i,
  input  logic [DATA_WIDTH-1:0] addr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  output logic                  stall_o,
  output logic                  done_o,
  output logic [DATA_WIDTH-1:0] rdata_o,
  output logic                  misalign_o,
  output logic                  err_o,
  output logic                  mem_req_o,
  output logic                  mem_we_o,
  output logic [3:0]            mem_be_o,
  output logic [DATA_WIDTH-1:0] mem_addr_o,
  output logic [DATA_WIDTH-1:0] mem_wdata_o,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i,
  input  logic                  mem_ack_i
);
  typedef enum logic [1:0] {IDLE, REQ, DONE, FAULT} state_t;
  state_t state, state_n;
  logic is_store, active, byte_w, half_w, mis, timeout, we_q, mis_q;
  logic [3:0] be_n, be_q;
  logic [2:0] ltype_q;
  logic [DATA_WIDTH-1:0] wdata_n, wdata_q, addr_q, lane, ext, cnt;
  assign is_store = store_type_i != 2'b00;
  assign active = req_valid_i && (is_store || load_en_i);
  assign byte_w = is_store ? store_type_i == 2'b11 : (load_type_i == 3'b011 || load_type_i == 3'b111);
  assign half_w = is_store ? store_type_i == 2'b10 : (load_type_i == 3'b010 || load_type_i == 3'b110);
  assign mis = half_w ? addr_i[0] : (!byte_w && addr_i[1:0] != 2'b00);
  assign be_n = byte_w ? 4'b0001 << addr_i[1:0] : half_w ? (addr_i[1] ? 4'b1100 : 4'b0011) : 4'b1111;
  assign wdata_n = byte_w ? {4{wdata_i[7:0]}} : half_w ? {2{wdata_i[15:0]}} : wdata_i;
  assign lane = mem_rdata_i >> {addr_q[1:0], 3'b000};
  assign ext = ltype_q == 3'b011 ? {{24{lane[7]}}, lane[7:0]} :
               ltype_q == 3'b111 ? {24'b0, lane[7:0]} :
               ltype_q == 3'b010 ? {{16{lane[15]}}, lane[15:0]} :
               ltype_q == 3'b110 ? {16'b0, lane[15:0]} : mem_rdata_i;
  assign timeout = TIMEOUT_CYCLES > 0 && cnt == DATA_WIDTH'(TIMEOUT_CYCLES - 1);
  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    state_n = active ? (mis ? FAULT : REQ) : IDLE;
      REQ:     state_n = mem_ack_i ? DONE : timeout ? FAULT : REQ;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= IDLE;
      cnt <= '0;
      addr_q <= '0;
      wdata_q <= '0;
      be_q <= '0;
      we_q <= 1'b0;
      ltype_q <= '0;
      mis_q <= 1'b0;
      rdata_o <= '0;
    end else begin
      state <= state_n;
      if (state == IDLE && active) begin
        addr_q <= addr_i;
        wdata_q <= wdata_n;
        be_q <= be_n;
        we_q <= is_store;
        ltype_q <= load_type_i;
        mis_q <= mis;
        cnt <= '0;
      end
      if (state == REQ) cnt <= cnt + 1'b1;
      if (state == REQ && mem_ack_i && !we_q) rdata_o <= ext;
    end
  end
  // bus outputs are gated so they read zero outside an active request
  assign mem_req_o = state == REQ;
  assign mem_we_o = mem_req_o && we_q;
  assign mem_be_o = mem_req_o ? be_q : 4'b0;
  assign mem_addr_o = mem_req_o ? {addr_q[DATA_WIDTH-1:2], 2'b00} : '0;
  assign mem_wdata_o = mem_req_o ? wdata_q : '0;
  assign stall_o = (state == IDLE && active) || state == REQ;
  assign done_o = state == DONE || state == FAULT;
  assign misalign_o = state == FAULT && mis_q;
  assign err_o = state == FAULT && !mis_q;
endmodule

// File: tb/tb_lsu_mem_if.sv
// tb_lsu_mem_if: directed self-checking bench for the load/store unit
module tb_lsu_mem_if;
  logic clk = 0;
  always #5 clk = ~clk;
  logic rst, req_valid, load_en, mem_ack;
  logic [1:0] store_type;
  logic [2:0] load_type;
  logic [31:0] addr, wdata, mem_rdata;
  logic stall_o, done_o, misalign_o, err_o, mem_req_o, mem_we_o;
  logic [3:0] mem_be_o;
  logic [31:0] rdata_o, mem_addr_o, mem_wdata_o;
  int n_chk = 0, n_fail = 0;
  int stall_cnt, done_cnt, req_cnt;
  logic o_we, o_mis, o_err;
  logic [3:0] o_be;
  logic [31:0] o_addr, o_wdata, o_rdata;

  lsu_mem_if dut (
    .clk_i(clk), .rst_i(rst), .req_valid_i(req_valid), .store_type_i(store_type),
    .load_en_i(load_en), .load_type_i(load_type), .addr_i(addr), .wdata_i(wdata),
    .stall_o(stall_o), .done_o(done_o), .rdata_o(rdata_o), .misalign_o(misalign_o),
    .err_o(err_o), .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_be_o(mem_be_o),
    .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata),
    .mem_ack_i(mem_ack)
  );

  // Presents one request, acks after ack_delay REQ cycles, and records what the bus and handshake did.
  task automatic do_access(input logic [1:0] st, input logic le, input logic [2:0] lt,
                           input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rd,
                           input int ack_delay);
    @(posedge clk); #1;
    req_valid = 1; store_type = st; load_en = le; load_type = lt; addr = a; wdata = wd;
    mem_rdata = rd; mem_ack = 0;
    stall_cnt = 0; done_cnt = 0; req_cnt = 0;
    o_we = 0; o_be = 0; o_addr = 0; o_wdata = 0; o_mis = 0; o_err = 0; o_rdata = 0;
    for (int c = 0; c < 40; c++) begin
      #1;
      if (stall_o) stall_cnt++;
      if (mem_req_o) begin
        o_we = mem_we_o; o_be = mem_be_o; o_addr = mem_addr_o; o_wdata = mem_wdata_o;
        mem_ack = (req_cnt == ack_delay);
        req_cnt++;
      end
      if (done_o) begin
        done_cnt++; o_mis = misalign_o; o_err = err_o; o_rdata = rdata_o;
        break;
      end
      @(posedge clk); #1;
      req_valid = 0; mem_ack = 0;
    end
    req_valid = 0; mem_ack = 0;
  endtask

  task automatic test_reset;
    rst = 1;
    repeat (2) @(posedge clk);
    #1;
    n_chk++; if ({stall_o, done_o, misalign_o, err_o, mem_req_o, mem_we_o, mem_be_o} !== 10'b0) begin n_fail++; $display("FAIL reset_ctrl got %b exp 0", {stall_o, done_o, misalign_o, err_o, mem_req_o, mem_we_o, mem_be_o}); end
    n_chk++; if (rdata_o !== 32'h0) begin n_fail++; $display("FAIL reset_rdata got %h exp 0", rdata_o); end
    n_chk++; if (mem_addr_o !== 32'h0) begin n_fail++; $display("FAIL reset_addr got %h exp 0", mem_addr_o); end
    n_chk++; if (mem_wdata_o !== 32'h0) begin n_fail++; $display("FAIL reset_wdata got %h exp 0", mem_wdata_o); end
    rst = 0;
  endtask

  task automatic test_store;
    do_access(2'b01, 0, 3'b001, 32'h100, 32'hDEADBEEF, 32'h0, 0);
    n_chk++; if (o_addr !== 32'h100) begin n_fail++; $display("FAIL sw_addr got %h exp 100", o_addr); end
    n_chk++; if ({o_we, o_be} !== 5'b11111) begin n_fail++; $display("FAIL sw_we_be got %b exp 11111", {o_we, o_be}); end
    n_chk++; if (o_wdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL sw_wdata got %h exp deadbeef", o_wdata); end
    n_chk++; if (stall_cnt !== 2) begin n_fail++; $display("FAIL sw_stall got %0d exp 2", stall_cnt); end
    n_chk++; if (done_cnt !== 1 || o_mis !== 0 || o_err !== 0) begin n_fail++; $display("FAIL sw_done got %0d/%b/%b exp 1/0/0", done_cnt, o_mis, o_err); end
    @(posedge clk); #1;
    n_chk++; if (done_o !== 0) begin n_fail++; $display("FAIL sw_done_pulse got %b exp 0", done_o); end
    do_access(2'b11, 0, 3'b001, 32'h103, 32'h000000A5, 32'h0, 0);
    n_chk++; if (o_be !== 4'b1000 || o_we !== 1) begin n_fail++; $display("FAIL sb_be got %b/%b exp 1000/1", o_be, o_we); end
    n_chk++; if (o_wdata !== 32'hA5A5A5A5) begin n_fail++; $display("FAIL sb_wdata got %h exp a5a5a5a5", o_wdata); end
    n_chk++; if (o_addr !== 32'h100) begin n_fail++; $display("FAIL sb_addr got %h exp 100", o_addr); end
    do_access(2'b10, 0, 3'b001, 32'h102, 32'h0000BEEF, 32'h0, 0);
    n_chk++; if (o_be !== 4'b1100 || o_wdata !== 32'hBEEFBEEF) begin n_fail++; $display("FAIL sh_lane got %b/%h exp 1100/beefbeef", o_be, o_wdata); end
  endtask

  task automatic test_load_ext;
    do_access(2'b00, 1, 3'b011, 32'h202, 32'h0, 32'h12F45678, 0);
    n_chk++; if (o_rdata !== 32'hFFFFFFF4) begin n_fail++; $display("FAIL lb_data got %h exp fffffff4", o_rdata); end
    n_chk++; if (o_be !== 4'b0100 || o_we !== 0 || o_addr !== 32'h200) begin n_fail++; $display("FAIL lb_bus got %b/%b/%h exp 0100/0/200", o_be, o_we, o_addr); end
    do_access(2'b00, 1, 3'b111, 32'h202, 32'h0, 32'h12F45678, 0);
    n_chk++; if (o_rdata !== 32'h000000F4) begin n_fail++; $display("FAIL lbu_data got %h exp 000000f4", o_rdata); end
    do_access(2'b00, 1, 3'b010, 32'h202, 32'h0, 32'h12F45678, 0);
    n_chk++; if (o_rdata !== 32'h000012F4 || o_be !== 4'b1100) begin n_fail++; $display("FAIL lh_data got %h/%b exp 000012f4/1100", o_rdata, o_be); end
    do_access(2'b00, 1, 3'b010, 32'h200, 32'h0, 32'h12348001, 0);
    n_chk++; if (o_rdata !== 32'hFFFF8001 || o_be !== 4'b0011) begin n_fail++; $display("FAIL lh_neg got %h/%b exp ffff8001/0011", o_rdata, o_be); end
    do_access(2'b00, 1, 3'b110, 32'h200, 32'h0, 32'h12348001, 0);
    n_chk++; if (o_rdata !== 32'h00008001) begin n_fail++; $display("FAIL lhu_data got %h exp 00008001", o_rdata); end
    do_access(2'b00, 1, 3'b101, 32'h300, 32'h0, 32'hCAFEF00D, 0);
    n_chk++; if (o_rdata !== 32'hCAFEF00D || o_be !== 4'b1111) begin n_fail++; $display("FAIL lw_other_code got %h/%b exp cafef00d/1111", o_rdata, o_be); end
  endtask

  task automatic test_store_priority;
    do_access(2'b10, 1, 3'b011, 32'h102, 32'h0000BEEF, 32'h99999999, 0);
    n_chk++; if (o_we !== 1 || o_be !== 4'b1100) begin n_fail++; $display("FAIL prio_we_be got %b/%b exp 1/1100", o_we, o_be); end
    n_chk++; if (rdata_o !== 32'hCAFEF00D) begin n_fail++; $display("FAIL prio_rdata_hold got %h exp cafef00d", rdata_o); end
  endtask

  task automatic test_misalign;
    do_access(2'b00, 1, 3'b001, 32'h301, 32'h0, 32'h11111111, 0);
    n_chk++; if (done_cnt !== 1 || o_mis !== 1 || o_err !== 0) begin n_fail++; $display("FAIL lw_mis got %0d/%b/%b exp 1/1/0", done_cnt, o_mis, o_err); end
    n_chk++; if (req_cnt !== 0) begin n_fail++; $display("FAIL lw_mis_req got %0d exp 0", req_cnt); end
    n_chk++; if (stall_cnt !== 1) begin n_fail++; $display("FAIL lw_mis_stall got %0d exp 1", stall_cnt); end
    n_chk++; if (rdata_o !== 32'hCAFEF00D) begin n_fail++; $display("FAIL mis_rdata_hold got %h exp cafef00d", rdata_o); end
    do_access(2'b10, 0, 3'b001, 32'h101, 32'h1234, 32'h0, 0);
    n_chk++; if (o_mis !== 1 || req_cnt !== 0) begin n_fail++; $display("FAIL sh_mis got %b/%0d exp 1/0", o_mis, req_cnt); end
    do_access(2'b00, 1, 3'b010, 32'h202, 32'h0, 32'h0, 0);
    n_chk++; if (o_mis !== 0 || done_cnt !== 1) begin n_fail++; $display("FAIL lh_aligned got %b/%0d exp 0/1", o_mis, done_cnt); end
  endtask

  task automatic test_timeout;
    do_access(2'b00, 1, 3'b001, 32'h500, 32'h0, 32'h55555555, 100);
    n_chk++; if (done_cnt !== 1 || o_err !== 1 || o_mis !== 0) begin n_fail++; $display("FAIL to_err got %0d/%b/%b exp 1/1/0", done_cnt, o_err, o_mis); end
    n_chk++; if (req_cnt !== 16) begin n_fail++; $display("FAIL to_req_cycles got %0d exp 16", req_cnt); end
    n_chk++; if (mem_req_o !== 0 || stall_o !== 0) begin n_fail++; $display("FAIL to_req_drop got %b/%b exp 0/0", mem_req_o, stall_o); end
    n_chk++; if (o_rdata !== 32'h0) begin n_fail++; $display("FAIL to_rdata_hold got %h exp 0", o_rdata); end
  endtask

  task automatic test_back_to_back;
    do_access(2'b00, 1, 3'b111, 32'h401, 32'h0, 32'hAABBCCDD, 2);
    n_chk++; if (stall_cnt !== 4 || req_cnt !== 3) begin n_fail++; $display("FAIL wait_stall got %0d/%0d exp 4/3", stall_cnt, req_cnt); end
    n_chk++; if (o_rdata !== 32'h000000CC || o_be !== 4'b0010) begin n_fail++; $display("FAIL wait_lbu got %h/%b exp 000000cc/0010", o_rdata, o_be); end
    do_access(2'b01, 0, 3'b001, 32'h404, 32'h01020304, 32'h0, 0);
    n_chk++; if (o_addr !== 32'h404 || stall_cnt !== 2) begin n_fail++; $display("FAIL b2b_sw got %h/%0d exp 404/2", o_addr, stall_cnt); end
  endtask

  task automatic test_stray_ack;
    @(posedge clk); #1;
    mem_ack = 1;
    repeat (2) @(posedge clk);
    #1;
    n_chk++; if (done_o !== 0 || stall_o !== 0 || mem_req_o !== 0) begin n_fail++; $display("FAIL stray_ack got %b%b%b exp 000", done_o, stall_o, mem_req_o); end
    mem_ack = 0;
  endtask

  task automatic test_reset_mid;
    @(posedge clk); #1;
    req_valid = 1; store_type = 2'b01; load_en = 0; addr = 32'h400; wdata = 32'h11223344;
    @(posedge clk); #1;
    req_valid = 0;
    n_chk++; if (mem_req_o !== 1) begin n_fail++; $display("FAIL rst_mid_req got %b exp 1", mem_req_o); end
    rst = 1;
    @(posedge clk); #1;
    n_chk++; if ({mem_req_o, mem_we_o, mem_be_o, stall_o, done_o} !== 8'b0 || mem_addr_o !== 0 || rdata_o !== 0) begin n_fail++; $display("FAIL rst_mid_clear got %b/%h/%h exp 0", {mem_req_o, mem_we_o, mem_be_o, stall_o, done_o}, mem_addr_o, rdata_o); end
    rst = 0; mem_ack = 1;
    @(posedge clk); #1;
    mem_ack = 0;
    n_chk++; if (done_o !== 0 || mem_req_o !== 0 || stall_o !== 0) begin n_fail++; $display("FAIL rst_late_ack got %b%b%b exp 000", done_o, mem_req_o, stall_o); end
    @(posedge clk); #1;
    n_chk++; if (done_o !== 0) begin n_fail++; $display("FAIL rst_late_done got %b exp 0", done_o); end
  endtask

  initial begin
    rst = 1; req_valid = 0; store_type = 0; load_en = 0; load_type = 0;
    addr = 0; wdata = 0; mem_rdata = 0; mem_ack = 0;
    test_reset;
    test_store;
    test_load_ext;
    test_store_priority;
    test_misalign;
    test_timeout;
    test_back_to_back;
    test_stray_ack;
    test_reset_mid;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/lsu_mem_if.md
Name: lsu_mem_if

Overview:
Load/store unit that executes the memory commands issued by the control unit. It takes the store-width code (MemWrite) and load-width code (RegWrite) with the ALU address and rs2 data, and runs a multi-cycle request/acknowledge transaction on the data-memory bus. It stalls the core until the access completes. On loads it returns the byte, half or word, sign- or zero-extended, for the Resultsrc=01 writeback path.

Parameters:
DATA_WIDTH, 32, data and address width; only 32 is supported.
TIMEOUT_CYCLES, 16, maximum cycles in REQ without mem_ack_i before an error is raised; 0 disables the timeout.

Ports:
clk_i  input  1  clock; all state updates on the rising edge.
rst_i  input  1  synchronous, active-high reset.
req_valid_i  input  1  execute stage presents a memory instruction this cycle.
store_type_i  input  2  00 none, 01 sw, 10 sh, 11 sb.
load_en_i  input  1  instruction is a load (Resultsrc=01).
load_type_i  input  3  001 lw, 010 lh, 011 lb, 110 lhu, 111 lbu; other values are treated as lw.
addr_i  input  32  byte address from the ALU.
wdata_i  input  32  store data (rs2).
stall_o  output  1  hold PC and pipeline registers.
done_o  output  1  one-cycle pulse when the access has finished.
rdata_o  output  32  extended load result; valid while done_o=1 and held until the next load completes.
misalign_o  output  1  with done_o: the access was misaligned and was not performed.
err_o  output  1  with done_o: the memory bus timed out.
mem_req_o  output  1  bus request.
mem_we_o  output  1  1 = write.
mem_be_o  output  4  byte enables.
mem_addr_o  output  32  word-aligned address ({addr[31:2],2'b00}).
mem_wdata_o  output  32  lane-replicated store data.
mem_rdata_i  input  32  read word; valid in the cycle mem_ack_i=1.
mem_ack_i  input  1  bus completes the request.

Behaviour:
- Reset: state=IDLE, timeout counter=0, and all outputs 0 (rdata_o=0, mem_* = 0).
- An operation is active when req_valid_i=1 and (store_type_i!=00 or load_en_i=1). A store takes priority: if both are set, the access is performed as a store.
- FSM states: IDLE, REQ, DONE, FAULT.
- IDLE:
  - If an operation is active and aligned, capture addr, data, type, byte enables and direction, then go to REQ.
  - If an operation is active and misaligned (half-word with addr[0]=1, or word with addr[1:0]!=00), go to FAULT. No bus access is made.
  - Otherwise stay in IDLE.
- REQ:
  - mem_req_o=1 and all mem_* outputs are driven from the captured registers, held stable until acknowledge.
  - On mem_ack_i=1: for a load, register the extended data into rdata_o; go to DONE.
  - If TIMEOUT_CYCLES>0 and the counter reaches TIMEOUT_CYCLES-1 with no acknowledge, go to FAULT with err_o set.
- DONE: done_o=1 for exactly one cycle, then return to IDLE. req_valid_i is ignored in DONE, because the pipeline advances in this cycle.
- FAULT: done_o=1 together with misalign_o or err_o for one cycle, then return to IDLE. rdata_o is unchanged.
- stall_o = (IDLE and operation active) or REQ. It is 0 in DONE and FAULT. Minimum latency is request accepted, then ack in the first REQ cycle, then DONE, which gives 2 stall cycles.
- Byte enables and write data by type:
  - sb: be = 0001 << addr[1:0]; wdata = {4{wdata[7:0]}}.
  - sh: be = addr[1] ? 1100 : 0011; wdata = {2{wdata[15:0]}}.
  - sw: be = 1111; wdata = wdata.
  - Loads use the same be pattern for their width, with mem_we_o=0.
- Load extraction: the selected lane is mem_rdata_i >> (8*addr[1:0]).
  - lb / lh: sign-extend bit 7 / bit 15.
  - lbu / lhu: zero-extend.
  - lw: full word.
- A mem_ack_i that arrives in any state other than REQ is ignored.
- Reset in mid-operation: mem_req_o=0 from the cycle after rst_i is sampled, and the pending transaction is abandoned.

Test Plan:
- sw addr=0x100, wdata=0xDEADBEEF, ack on the 1st REQ cycle -> mem_addr=0x100, be=1111, we=1; stall_o high for 2 cycles; done_o pulses once.
- sb addr=0x103, wdata=0x000000A5 -> be=1000, mem_wdata=0xA5A5A5A5, mem_addr=0x100.
- lb addr=0x202 with mem_rdata=0x12F45678 -> rdata_o=0xFFFFFFF4; lbu with the same inputs -> 0x000000F4; lh addr=0x202 -> 0x000012F4.
- lw addr=0x301 -> misalign_o=1 with done_o; mem_req_o is never asserted; stall_o=1 for 1 cycle.
- Load with no ack for 16 cycles -> err_o=1 with done_o on the following cycle; mem_req_o drops.
- Assert rst_i during REQ of a store, then give a late ack -> all outputs 0 and state IDLE; the ack is ignored and done_o stays 0.
